// File: rtl/minmax_pkg.sv
// Shared types and constants for the min/max burst scanner.
package minmax_pkg;

    localparam int DATA_W = 8;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ACCEPT  = 3'd1,
        S_CMP_MAX = 3'd2,
        S_CMP_MIN = 3'd3,
        S_DONE    = 3'd4
    } state_e;

endpackage

// File: rtl/eightbitcomparator.sv
// Unsigned 8-bit magnitude comparator: gr = a>b, eq = a==b, le = a<b.
module eightbitcomparator
    import minmax_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic              gr,
    output logic              eq,
    output logic              le
);

    assign gr = (a > b);
    assign eq = (a == b);
    assign le = (a < b);

endmodule

// File: rtl/minmax_scan_ctrl.sv
// Scans a burst of COUNT unsigned samples, tracking max/min and their first-occurrence
// indices with a single comparator shared between the max and min steps.
module minmax_scan_ctrl
    import minmax_pkg::*;
#(
    parameter  int COUNT = 8,
    localparam int IDX_W = (COUNT > 1) ? $clog2(COUNT) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] max_out,
    output logic [DATA_W-1:0] min_out,
    output logic [IDX_W-1:0]  max_idx,
    output logic [IDX_W-1:0]  min_idx
);

    localparam logic [IDX_W-1:0] LAST = IDX_W'(COUNT - 1);

    state_e            state_q, state_d;
    logic [IDX_W-1:0]  count_q, count_d;
    logic [DATA_W-1:0] sample_q, sample_d;
    logic [DATA_W-1:0] max_q, max_d, min_q, min_d;
    logic [IDX_W-1:0]  maxi_q, maxi_d, mini_q, mini_d;

    logic [DATA_W-1:0] cmp_a, cmp_b;
    logic              cmp_gr, cmp_eq_unused, cmp_le;

    // Comparator operands are parked at zero outside the two compare states.
    always_comb begin
        cmp_a = '0;
        cmp_b = '0;
        if (state_q == S_CMP_MAX) begin
            cmp_a = sample_q;
            cmp_b = max_q;
        end else if (state_q == S_CMP_MIN) begin
            cmp_a = sample_q;
            cmp_b = min_q;
        end
    end

    eightbitcomparator u_cmp (
        .a  (cmp_a),
        .b  (cmp_b),
        .gr (cmp_gr),
        .eq (cmp_eq_unused),
        .le (cmp_le)
    );

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        sample_d = sample_q;
        max_d    = max_q;
        min_d    = min_q;
        maxi_d   = maxi_q;
        mini_d   = mini_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_ACCEPT;
                    count_d = '0;
                end
            end
            S_ACCEPT: begin
                if (in_valid) begin
                    if (count_q == '0) begin
                        // First sample seeds both extremes; results of the previous burst are dropped here.
                        max_d  = in_data;
                        min_d  = in_data;
                        maxi_d = '0;
                        mini_d = '0;
                        if (COUNT == 1) begin
                            state_d = S_DONE;
                        end else begin
                            count_d = count_q + 1'b1;
                        end
                    end else begin
                        sample_d = in_data;
                        state_d  = S_CMP_MAX;
                    end
                end
            end
            S_CMP_MAX: begin
                if (cmp_gr) begin
                    max_d  = sample_q;
                    maxi_d = count_q;
                end
                state_d = S_CMP_MIN;
            end
            S_CMP_MIN: begin
                if (cmp_le) begin
                    min_d  = sample_q;
                    mini_d = count_q;
                end
                if (count_q == LAST) begin
                    state_d = S_DONE;
                end else begin
                    count_d = count_q + 1'b1;
                    state_d = S_ACCEPT;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            count_q  <= '0;
            sample_q <= '0;
            max_q    <= '0;
            min_q    <= '0;
            maxi_q   <= '0;
            mini_q   <= '0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            sample_q <= sample_d;
            max_q    <= max_d;
            min_q    <= min_d;
            maxi_q   <= maxi_d;
            mini_q   <= mini_d;
        end
    end

    assign in_ready = (state_q == S_ACCEPT);
    assign busy     = (state_q != S_IDLE);
    assign done     = (state_q == S_DONE);
    assign max_out  = max_q;
    assign min_out  = min_q;
    assign max_idx  = maxi_q;
    assign min_idx  = mini_q;

endmodule

// File: tb/tb_minmax_scan_ctrl.sv
// Scoreboard bench for minmax_scan_ctrl with three burst lengths (8, 4, 1).
module tb_minmax_scan_ctrl;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic       start_s [3];
    logic       vld_s   [3];
    logic [7:0] dat_s   [3];
    logic       rdy     [3];
    logic       busy    [3];
    logic       done    [3];
    logic [7:0] mx      [3];
    logic [7:0] mn      [3];
    logic [7:0] mxi     [3];
    logic [7:0] mni     [3];
    logic [2:0] mxi0, mni0;
    logic [1:0] mxi1, mni1;
    logic       mxi2, mni2;

    assign mxi[0] = {5'b0, mxi0};
    assign mni[0] = {5'b0, mni0};
    assign mxi[1] = {6'b0, mxi1};
    assign mni[1] = {6'b0, mni1};
    assign mxi[2] = {7'b0, mxi2};
    assign mni[2] = {7'b0, mni2};

    minmax_scan_ctrl #(.COUNT(8)) dut8 (
        .clk(clk), .rst(rst), .start(start_s[0]), .in_valid(vld_s[0]), .in_data(dat_s[0]),
        .in_ready(rdy[0]), .busy(busy[0]), .done(done[0]), .max_out(mx[0]), .min_out(mn[0]),
        .max_idx(mxi0), .min_idx(mni0));
    minmax_scan_ctrl #(.COUNT(4)) dut4 (
        .clk(clk), .rst(rst), .start(start_s[1]), .in_valid(vld_s[1]), .in_data(dat_s[1]),
        .in_ready(rdy[1]), .busy(busy[1]), .done(done[1]), .max_out(mx[1]), .min_out(mn[1]),
        .max_idx(mxi1), .min_idx(mni1));
    minmax_scan_ctrl #(.COUNT(1)) dut1 (
        .clk(clk), .rst(rst), .start(start_s[2]), .in_valid(vld_s[2]), .in_data(dat_s[2]),
        .in_ready(rdy[2]), .busy(busy[2]), .done(done[2]), .max_out(mx[2]), .min_out(mn[2]),
        .max_idx(mxi2), .min_idx(mni2));

    int cnt [3] = '{8, 4, 1};

    typedef struct {
        int d;
        int mx, mn, mxi, mni;
        int cyc;
    } exp_t;

    exp_t sbq[$];
    int   errors = 0;
    int   checks = 0;
    logic prev_done [3] = '{1'b0, 1'b0, 1'b0};

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitor: every done pulse pops the oldest expectation and compares it.
    always @(negedge clk) begin
        if (rst !== 1'b1) begin
            for (int d = 0; d < 3; d++) begin
                if (done[d] === 1'b1) begin
                    exp_t e;
                    chk("done_single_cycle", int'(prev_done[d]), 0);
                    if (sbq.size() == 0) begin
                        chk("unexpected_done", 1, 0);
                    end else begin
                        e = sbq.pop_front();
                        chk("done_dut", d, e.d);
                        chk("max_out", int'(mx[d]), e.mx);
                        chk("min_out", int'(mn[d]), e.mn);
                        chk("max_idx", int'(mxi[d]), e.mxi);
                        chk("min_idx", int'(mni[d]), e.mni);
                        chk("done_cycle", cyc, e.cyc);
                        chk("busy_in_done", int'(busy[d]), 1);
                    end
                end
            end
        end
        for (int d = 0; d < 3; d++) prev_done[d] <= done[d];
    end

    // Reference: the largest/smallest value and the lowest index holding it.
    function automatic exp_t model(input int d, input int unsigned s[$], input int stl[$], input int st);
        exp_t e;
        int stall_sum = 0;
        e.d = d;
        e.mx = int'(s[0]);
        e.mn = int'(s[0]);
        e.mxi = 0;
        e.mni = 0;
        foreach (s[i]) begin
            if (int'(s[i]) > e.mx) begin e.mx = int'(s[i]); e.mxi = i; end
            if (int'(s[i]) < e.mn) begin e.mn = int'(s[i]); e.mni = i; end
            stall_sum += stl[i];
        end
        e.cyc = st + 3 * (s.size() - 1) + 2 + stall_sum;
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs one burst; abort_after>=0 stops after that many samples without an expectation.
    task automatic run_burst(input int d, input int unsigned s[$], input int stl[$],
                             input int poke, input int abort_after);
        int w;
        if (abort_after < 0) sbq.push_back(model(d, s, stl, cyc));
        start_s[d] = 1'b1;
        tick();
        start_s[d] = 1'b0;
        foreach (s[i]) begin
            if (abort_after >= 0 && i == abort_after) return;
            w = 0;
            while (rdy[d] !== 1'b1 && w < 50) begin tick(); w++; end
            if (w >= 50) chk("ready_timeout", 0, 1);
            repeat (stl[i]) tick();
            vld_s[d] = 1'b1;
            dat_s[d] = s[i][7:0];
            tick();
            vld_s[d] = 1'b0;
            dat_s[d] = 8'hxx;
            if (i == poke) begin
                start_s[d] = 1'b1;
                tick();
                start_s[d] = 1'b0;
            end
        end
        w = 0;
        while (busy[d] !== 1'b0 && w < 50) begin tick(); w++; end
        if (w >= 50) chk("busy_timeout", 0, 1);
    endtask

    function automatic void fill_stalls(output int stl[$], input int n, input int v);
        stl = {};
        for (int i = 0; i < n; i++) stl.push_back(v);
    endfunction

    initial begin
        int unsigned s2[$] = '{45, 201, 15, 255, 0, 145, 32, 64};
        int unsigned sflat[$] = '{45, 45, 45, 45, 45, 45, 45, 45};
        int unsigned stie[$] = '{200, 201, 201, 200};
        int unsigned sone[$] = '{77};
        int unsigned sr[$];
        int stl[$];
        int w;

        rst = 1'b0;
        for (int d = 0; d < 3; d++) begin
            start_s[d] = 1'b0;
            vld_s[d]   = 1'b0;
            dat_s[d]   = 8'h00;
        end

        #2 rst = 1'b1;
        #1;
        chk("rst_max", int'(mx[0]), 0);
        chk("rst_min", int'(mn[0]), 0);
        chk("rst_busy", int'(busy[0]), 0);
        chk("rst_ready", int'(rdy[0]), 0);
        chk("rst_done", int'(done[0]), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        tick();
        for (int i = 0; i < 5; i++) begin
            chk("idle_busy", int'(busy[0]), 0);
            chk("idle_ready", int'(rdy[0]), 0);
            tick();
        end

        fill_stalls(stl, 8, 0);
        run_burst(0, s2, stl, -1, -1);
        run_burst(0, sflat, stl, -1, -1);
        fill_stalls(stl, 4, 0);
        run_burst(1, stie, stl, -1, -1);
        fill_stalls(stl, 8, 2);
        run_burst(0, s2, stl, -1, -1);
        fill_stalls(stl, 8, 0);
        run_burst(0, s2, stl, 2, -1);

        run_burst(0, s2, stl, -1, 3);
        #2 rst = 1'b1;
        #1;
        chk("abort_max", int'(mx[0]), 0);
        chk("abort_min", int'(mn[0]), 0);
        chk("abort_maxidx", int'(mxi[0]), 0);
        chk("abort_minidx", int'(mni[0]), 0);
        chk("abort_busy", int'(busy[0]), 0);
        chk("abort_ready", int'(rdy[0]), 0);
        @(negedge clk);
        rst = 1'b0;
        tick();
        run_burst(0, s2, stl, -1, -1);

        fill_stalls(stl, 1, 0);
        run_burst(2, sone, stl, -1, -1);

        for (int b = 0; b < 9; b++) begin
            int d = b % 3;
            int narrow = $urandom_range(0, 1);
            sr = {};
            stl = {};
            for (int i = 0; i < cnt[d]; i++) begin
                sr.push_back(narrow ? $urandom_range(0, 3) : $urandom_range(0, 255));
                stl.push_back($urandom_range(0, 2));
            end
            run_burst(d, sr, stl, -1, -1);
        end

        w = 0;
        while (sbq.size() != 0 && w < 100) begin tick(); w++; end
        chk("scoreboard_drained", sbq.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
